kmeans_iter_ctrl: RTL and testbench
===================================

Name: kmeans_iter_ctrl

Overview:
Sequences one K-means run on the clustering datapath once the register block's GO bit is set. Each iteration streams every point address from first_addr to last_addr into the assignment/accumulate datapath, then requests the 8 centroid updates and writes each new centroid back through the register-file core port. The run stops on convergence, on the iteration limit, or on a bad address range, and finishes with a one-cycle interrupt.

Parameters:
ADDR_W, 9, RAM address width
DATA_W, 91, centroid/point word width
REG_NUM_W, 4, register-number width
MANH_W, 16, Manhattan distance/threshold width
CENT_NUM, 8, number of centroids
MAX_ITER, 16, iteration limit, range 1..255
TIMEOUT_CYC, 1024, stall watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
go  in  1  GO register level from the register file
first_addr  in  ADDR_W  first point address
last_addr  in  ADDR_W  last point address, inclusive
threshold  in  MANH_W  convergence threshold
ram_rd_en  out  1  point RAM read strobe
ram_addr  out  ADDR_W  point RAM read address
dp_ready  in  1  datapath can accept a point this cycle
pt_valid  out  1  RAM data is valid for the datapath (ram_rd_en delayed 1 cycle)
acc_clear  out  1  clear the datapath accumulators, 1-cycle pulse
upd_start  out  1  request centroid update, 1-cycle pulse
upd_idx  out  3  centroid index 0..7
upd_done  in  1  update result valid, 1-cycle pulse
upd_centroid  in  DATA_W  new centroid value
upd_delta  in  MANH_W  Manhattan distance between old and new centroid
reg_write  out  1  core write strobe to the register file
reg_num  out  REG_NUM_W  target register: 2+upd_idx (cent_1..cent_8 = 2..9)
reg_write_data  out  DATA_W  centroid written to the register file
interrupt  out  1  run complete, 1-cycle pulse
done_code  out  2  00 converged, 01 MAX_ITER reached, 10 bad range, 11 timeout; held until the next start

Behaviour:
- Reset: state IDLE. All outputs are 0. Counters, latched config and done_code are 0.
- Reset is asynchronous and fully effective mid-run: no interrupt is raised and no further reg_write occurs.
- IDLE: when go=1, latch first_addr, last_addr and threshold, clear iter_cnt and done_code.
  - If first_addr > last_addr, go to DONE with code 10.
  - Otherwise go to CLEAR.
- CLEAR: drive acc_clear=1 for 1 cycle, increment iter_cnt, set addr=first, clear max_delta. Go to STREAM.
- STREAM:
  - ram_rd_en = dp_ready. ram_addr = addr.
  - addr increments only on a cycle with ram_rd_en=1.
  - When ram_rd_en=1 and addr==last, go to DRAIN. No wrap past last; last_addr = 2^ADDR_W-1 must not overflow.
  - pt_valid is ram_rd_en registered, giving exactly (last-first+1) pt_valid pulses per iteration.
- DRAIN: 1 cycle, so the final pt_valid issues. Then go to UPDATE with k=0.
- UPDATE(k):
  - Pulse upd_start with upd_idx=k, then wait for upd_done.
  - In the upd_done cycle: reg_write=1, reg_num=2+k, reg_write_data=upd_centroid (combinational, same cycle), and max_delta = max(max_delta, upd_delta).
  - k=7 done → CHECK, otherwise k+1.
  - upd_done arriving in the same cycle as upd_start is legal.
- CHECK:
  - max_delta <= threshold → DONE with code 00.
  - Else iter_cnt == MAX_ITER → DONE with code 01.
  - Else → CLEAR.
- DONE: interrupt=1 for exactly 1 cycle, then IDLE. The register file clears go on interrupt, so IDLE does not restart.
- go falling in any state other than IDLE/DONE: abort to IDLE next cycle. Strobes are deasserted, there is no interrupt, and done_code is unchanged.
- Strobes are registered. ram_rd_en, acc_clear, upd_start and interrupt are never high in the same cycle.

Optional Feature:
KMEANS_CTRL_TIMEOUT_EN:
- When defined: a watchdog counts consecutive stall cycles, i.e. STREAM with dp_ready=0, or UPDATE waiting on upd_done. It resets on progress. Reaching TIMEOUT_CYC goes to DONE with code 11 and raises interrupt.
- When undefined: the controller waits indefinitely, and code 11 is never produced.

Test Plan:
- first=0, last=3, dp_ready=1, all upd_delta=0, threshold=5 → ram_addr 0,1,2,3 on 4 consecutive cycles, 4 pt_valid, 8 reg_writes with reg_num 2..9, interrupt after 1 iteration, done_code 00.
- first=10, last=12, upd_delta=20 every iteration, threshold=5, MAX_ITER=3 → 3 acc_clear pulses, 24 reg_writes, done_code 01.
- first=5, last=4 → no ram_rd_en, interrupt 2 cycles after go, done_code 10.
- dp_ready toggled 1,0,0,1,... on range 0..7 → each address issued once, 8 pt_valid, no skipped or duplicated address.
- go deasserted during UPDATE k=3 → no further reg_write, no interrupt, IDLE next cycle. Also assert rst_n low mid-STREAM → all outputs 0 immediately.
- With KMEANS_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16, upd_done withheld → interrupt at the 16th stall cycle, done_code 11.

Source files
------------

// File: rtl/kmeans_iter_ctrl.sv
// ---------------------------------------------------------------------------------------------
// kmeans_iter_ctrl
//
// Sequences one K-means run once the register block's GO level is seen. Each iteration clears
// the datapath accumulators, streams every point address first..last into the datapath, then
// requests the centroid updates one by one and writes each new centroid back to the register
// file (cent_1..cent_8 live at register numbers 2..9). The run stops on convergence (largest
// centroid move <= threshold), on the iteration limit, or on an empty address range, and ends
// with a one-cycle interrupt.
//
// Optional build macro: KMEANS_CTRL_TIMEOUT_EN adds a stall watchdog (parameter TIMEOUT_CYC)
// that ends the run with done code 11 after TIMEOUT_CYC consecutive stall cycles.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   go_i                 GO register level; dropping it mid-run aborts silently
//   first_addr_i         first point address
//   last_addr_i          last point address, inclusive
//   threshold_i          convergence threshold on the largest Manhattan centroid move
//   ram_rd_en_o          point RAM read strobe (STREAM only, follows dp_ready_i)
//   ram_addr_o           point RAM read address
//   dp_ready_i           datapath can accept a point this cycle
//   pt_valid_o           RAM data valid for the datapath (ram_rd_en_o delayed one cycle)
//   acc_clear_o          clear datapath accumulators, one-cycle pulse per iteration
//   upd_start_o          request centroid update for upd_idx_o, one-cycle pulse
//   upd_idx_o            centroid index 0..7
//   upd_done_i           update result valid, one-cycle pulse
//   upd_centroid_i       new centroid value
//   upd_delta_i          Manhattan distance between old and new centroid
//   reg_write_o          register-file core write strobe (same cycle as upd_done_i)
//   reg_num_o            target register, 2 + upd_idx_o
//   reg_write_data_o     centroid written to the register file
//   interrupt_o          run complete, one-cycle pulse
//   done_code_o          00 converged, 01 iteration limit, 10 bad range, 11 timeout
// ---------------------------------------------------------------------------------------------

module kmeans_iter_ctrl #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 91,
    parameter int unsigned REG_NUM_W = 4,
    parameter int unsigned MANH_W    = 16,
    parameter int unsigned CENT_NUM  = 8,
    parameter int unsigned MAX_ITER  = 16
`ifdef KMEANS_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go_i,
    input  logic [ADDR_W-1:0]    first_addr_i,
    input  logic [ADDR_W-1:0]    last_addr_i,
    input  logic [MANH_W-1:0]    threshold_i,
    output logic                 ram_rd_en_o,
    output logic [ADDR_W-1:0]    ram_addr_o,
    input  logic                 dp_ready_i,
    output logic                 pt_valid_o,
    output logic                 acc_clear_o,
    output logic                 upd_start_o,
    output logic [2:0]           upd_idx_o,
    input  logic                 upd_done_i,
    input  logic [DATA_W-1:0]    upd_centroid_i,
    input  logic [MANH_W-1:0]    upd_delta_i,
    output logic                 reg_write_o,
    output logic [REG_NUM_W-1:0] reg_num_o,
    output logic [DATA_W-1:0]    reg_write_data_o,
    output logic                 interrupt_o,
    output logic [1:0]           done_code_o
);

    localparam logic [2:0] LastIdx     = 3'(CENT_NUM - 1);
    localparam logic [7:0] IterLimit   = 8'(MAX_ITER);
    localparam logic [1:0] CodeConv    = 2'b00;
    localparam logic [1:0] CodeMaxIter = 2'b01;
    localparam logic [1:0] CodeBadRng  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StUpdate,
        StCheck,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [MANH_W-1:0]   thr_q, thr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          iter_q, iter_d;
    logic [2:0]          k_q, k_d;
    logic [MANH_W-1:0]   max_delta_q, max_delta_d;
    logic [1:0]          done_code_q, done_code_d;
    logic                acc_clear_q, acc_clear_d;
    logic                upd_start_q, upd_start_d;
    logic                interrupt_q, interrupt_d;
    logic                pt_valid_q;

    // Combinational strobes that must follow their inputs in the same cycle.
    logic                rd_en;
    logic                wr_en;

`ifdef KMEANS_CTRL_TIMEOUT_EN
    localparam int unsigned WdW         = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [1:0]  CodeTimeout = 2'b11;

    logic [WdW-1:0]      wd_q, wd_d;
`endif

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        last_d      = last_q;
        thr_d       = thr_q;
        addr_d      = addr_q;
        iter_d      = iter_q;
        k_d         = k_q;
        max_delta_d = max_delta_q;
        done_code_d = done_code_q;
        acc_clear_d = 1'b0;
        upd_start_d = 1'b0;
        interrupt_d = 1'b0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
`ifdef KMEANS_CTRL_TIMEOUT_EN
        wd_d        = '0;
`endif

        case (state_q)
            StIdle: begin
                if (go_i) begin
                    first_d     = first_addr_i;
                    last_d      = last_addr_i;
                    thr_d       = threshold_i;
                    iter_d      = '0;
                    done_code_d = CodeConv;
                    if (first_addr_i > last_addr_i) begin
                        state_d     = StDone;
                        done_code_d = CodeBadRng;
                    end else begin
                        state_d = StClear;
                    end
                end
            end

            StClear: begin
                iter_d      = iter_q + 8'd1;
                addr_d      = first_q;
                max_delta_d = '0;
                state_d     = StStream;
            end

            StStream: begin
                rd_en = dp_ready_i;
                if (rd_en) begin
                    // Hold on the last address rather than incrementing, so last = all-ones
                    // never wraps.
                    if (addr_q == last_q) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end

            StDrain: begin
                k_d     = '0;
                state_d = StUpdate;
            end

            StUpdate: begin
                if (upd_done_i) begin
                    wr_en = 1'b1;
                    if (upd_delta_i > max_delta_q) begin
                        max_delta_d = upd_delta_i;
                    end
                    if (k_q == LastIdx) begin
                        state_d = StCheck;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end

            StCheck: begin
                if (max_delta_q <= thr_q) begin
                    state_d     = StDone;
                    done_code_d = CodeConv;
                end else if (iter_q == IterLimit) begin
                    state_d     = StDone;
                    done_code_d = CodeMaxIter;
                end else begin
                    state_d = StClear;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef KMEANS_CTRL_TIMEOUT_EN
        // Consecutive stall cycles; any progress (or leaving the stall states) restarts it.
        if ((state_q == StStream && !dp_ready_i) || (state_q == StUpdate && !upd_done_i)) begin
            if (wd_q == WdW'(TIMEOUT_CYC - 1)) begin
                state_d     = StDone;
                done_code_d = CodeTimeout;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
`endif

        // GO dropped mid-run: silent abort, no write, no interrupt, code untouched.
        if (!go_i && state_q != StIdle && state_q != StDone) begin
            state_d     = StIdle;
            done_code_d = done_code_q;
            rd_en       = 1'b0;
            wr_en       = 1'b0;
`ifdef KMEANS_CTRL_TIMEOUT_EN
            wd_d        = '0;
`endif
        end

        // Pulse strobes are flops aligned with the state they belong to.
        acc_clear_d = (state_d == StClear);
        interrupt_d = (state_d == StDone);
        upd_start_d = (state_d == StUpdate) && ((state_q != StUpdate) || (k_d != k_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            first_q     <= '0;
            last_q      <= '0;
            thr_q       <= '0;
            addr_q      <= '0;
            iter_q      <= '0;
            k_q         <= '0;
            max_delta_q <= '0;
            done_code_q <= '0;
            acc_clear_q <= 1'b0;
            upd_start_q <= 1'b0;
            interrupt_q <= 1'b0;
            pt_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            last_q      <= last_d;
            thr_q       <= thr_d;
            addr_q      <= addr_d;
            iter_q      <= iter_d;
            k_q         <= k_d;
            max_delta_q <= max_delta_d;
            done_code_q <= done_code_d;
            acc_clear_q <= acc_clear_d;
            upd_start_q <= upd_start_d;
            interrupt_q <= interrupt_d;
            pt_valid_q  <= rd_en;
        end
    end

`ifdef KMEANS_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign ram_rd_en_o      = rd_en;
    assign ram_addr_o       = addr_q;
    assign pt_valid_o       = pt_valid_q;
    assign acc_clear_o      = acc_clear_q;
    assign upd_start_o      = upd_start_q;
    assign upd_idx_o        = k_q;
    assign reg_write_o      = wr_en;
    assign reg_num_o        = wr_en ? (REG_NUM_W'(k_q) + REG_NUM_W'(2)) : '0;
    assign reg_write_data_o = wr_en ? upd_centroid_i : '0;
    assign interrupt_o      = interrupt_q;
    assign done_code_o      = done_code_q;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_kmeans_iter_ctrl
//
// Directed bench for kmeans_iter_ctrl (built with MAX_ITER = 3). A table of runs gives address
// ranges, threshold, the delta reported for centroid 5 (all others report 0), the dp_ready
// pattern and the update latency, together with hand-computed read, clear, write counts and the
// final done code. A small datapath responder answers update requests; a monitor checks the
// address sequence, pt_valid timing, register numbers/data and strobe exclusivity. Hand-written
// sequences cover the bad-range timing, a GO abort during update 3, reset mid-stream and, when
// KMEANS_CTRL_TIMEOUT_EN is defined, the watchdog.
// ---------------------------------------------------------------------------------------------

module tb_kmeans_iter_ctrl;

    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned DATA_W    = 91;
    localparam int unsigned REG_NUM_W = 4;
    localparam int unsigned MANH_W    = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 go = 1'b0;
    logic [ADDR_W-1:0]    first_addr = '0;
    logic [ADDR_W-1:0]    last_addr = '0;
    logic [MANH_W-1:0]    threshold = '0;
    logic                 ram_rd_en;
    logic [ADDR_W-1:0]    ram_addr;
    logic                 dp_ready = 1'b0;
    logic                 pt_valid;
    logic                 acc_clear;
    logic                 upd_start;
    logic [2:0]           upd_idx;
    logic                 upd_done = 1'b0;
    logic [DATA_W-1:0]    upd_centroid = '0;
    logic [MANH_W-1:0]    upd_delta = '0;
    logic                 reg_write;
    logic [REG_NUM_W-1:0] reg_num;
    logic [DATA_W-1:0]    reg_write_data;
    logic                 interrupt;
    logic [1:0]           done_code;

    // Stimulus knobs written by the main sequence only.
    int          dp_mode = 0;
    int          resp_lat = 0;
    bit          resp_en = 1'b1;
    int          delta_hi = 0;
    logic [87:0] cent_tag = '0;

    int checks = 0;
    int failures = 0;

    kmeans_iter_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .REG_NUM_W(REG_NUM_W),
        .MANH_W   (MANH_W),
        .CENT_NUM (8),
        .MAX_ITER (3)
`ifdef KMEANS_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .go_i            (go),
        .first_addr_i    (first_addr),
        .last_addr_i     (last_addr),
        .threshold_i     (threshold),
        .ram_rd_en_o     (ram_rd_en),
        .ram_addr_o      (ram_addr),
        .dp_ready_i      (dp_ready),
        .pt_valid_o      (pt_valid),
        .acc_clear_o     (acc_clear),
        .upd_start_o     (upd_start),
        .upd_idx_o       (upd_idx),
        .upd_done_i      (upd_done),
        .upd_centroid_i  (upd_centroid),
        .upd_delta_i     (upd_delta),
        .reg_write_o     (reg_write),
        .reg_num_o       (reg_num),
        .reg_write_data_o(reg_write_data),
        .interrupt_o     (interrupt),
        .done_code_o     (done_code)
    );

    always #5 clk = ~clk;

    // dp_ready: constantly high, or the repeating 1,0,0 pattern.
    int dp_cyc = 0;
    always @(posedge clk) begin
        #1;
        dp_ready = (dp_mode == 0) ? 1'b1 : ((dp_cyc % 3) == 0);
        dp_cyc++;
    end

    // Datapath responder: answers upd_start after resp_lat cycles (0 = same cycle).
    bit       pend = 1'b0;
    int       pend_cnt = 0;
    logic [2:0] pend_idx = '0;
    always @(posedge clk) begin
        #2;
        if (!resp_en) begin
            pend = 1'b0;
        end else if (upd_start) begin
            pend     = 1'b1;
            pend_cnt = resp_lat;
            pend_idx = upd_idx;
        end
        if (pend && pend_cnt == 0) begin
            upd_done     = 1'b1;
            upd_centroid = {cent_tag, pend_idx};
            upd_delta    = (pend_idx == 3'd5) ? MANH_W'(delta_hi) : '0;
            pend         = 1'b0;
        end else begin
            upd_done = 1'b0;
            if (pend) pend_cnt--;
        end
    end

    // Monitor: running event counts and protocol error counts.
    int n_rd = 0, n_pt = 0, n_clr = 0, n_wr = 0, n_int = 0;
    int addr_err = 0, pt_err = 0, wr_err = 0, excl_err = 0;
    int exp_addr = 0, wr_idx = 0;
    bit prev_rd = 1'b0, prev_ok = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_clear) begin
                exp_addr = int'(first_addr);
                wr_idx   = 0;
                n_clr++;
            end
            if (ram_rd_en) begin
                if (int'(ram_addr) != exp_addr) addr_err++;
                exp_addr++;
                n_rd++;
            end
            if (prev_ok && pt_valid !== prev_rd) pt_err++;
            if (pt_valid) n_pt++;
            if (reg_write) begin
                if (reg_num !== REG_NUM_W'(2 + wr_idx) ||
                    reg_write_data !== {cent_tag, 3'(wr_idx)}) wr_err++;
                wr_idx++;
                n_wr++;
            end
            if (interrupt) n_int++;
            if (int'(ram_rd_en) + int'(acc_clear) + int'(upd_start) + int'(interrupt) > 1)
                excl_err++;
            prev_rd = ram_rd_en;
            prev_ok = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int first;
        int last;
        int thr;
        int dhi;
        int dp;
        int lat;
        int exp_rd;
        int exp_clr;
        int exp_wr;
        int exp_code;
    } vec_t;

    task automatic run_vec(input vec_t v, input int vi);
        int b_rd, b_pt, b_clr, b_wr, b_int, b_ae, b_pe, b_we, b_xe;
        bit got;
        int code;
        b_rd = n_rd; b_pt = n_pt; b_clr = n_clr; b_wr = n_wr; b_int = n_int;
        b_ae = addr_err; b_pe = pt_err; b_we = wr_err; b_xe = excl_err;
        got  = 1'b0;
        code = -1;
        @(posedge clk);
        #1;
        first_addr = ADDR_W'(v.first);
        last_addr  = ADDR_W'(v.last);
        threshold  = MANH_W'(v.thr);
        delta_hi   = v.dhi;
        dp_mode    = v.dp;
        resp_lat   = v.lat;
        resp_en    = 1'b1;
        cent_tag   = {24'hC0FFEE, 32'(vi), 32'hDEAD_BEEF};
        go         = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (interrupt) begin
                got  = 1'b1;
                code = int'(done_code);
                break;
            end
        end
        go = 1'b0;
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_irq_seen", vi), got, 1);
        check($sformatf("v%0d_done_code", vi), code, v.exp_code);
        check($sformatf("v%0d_rd_cnt", vi), n_rd - b_rd, v.exp_rd);
        check($sformatf("v%0d_pt_cnt", vi), n_pt - b_pt, v.exp_rd);
        check($sformatf("v%0d_clr_cnt", vi), n_clr - b_clr, v.exp_clr);
        check($sformatf("v%0d_wr_cnt", vi), n_wr - b_wr, v.exp_wr);
        check($sformatf("v%0d_irq_cnt", vi), n_int - b_int, 1);
        check($sformatf("v%0d_addr_seq_err", vi), addr_err - b_ae, 0);
        check($sformatf("v%0d_pt_timing_err", vi), pt_err - b_pe, 0);
        check($sformatf("v%0d_reg_write_err", vi), wr_err - b_we, 0);
        check($sformatf("v%0d_strobe_excl_err", vi), excl_err - b_xe, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int  b_wr, b_int, cnt;
        bit  found;

        //            first last thr dhi dp lat  rd clr wr code
        vecs[0] = '{    0,   3,  5,  0, 0, 0,   4,  1,  8, 0};
        vecs[1] = '{   10,  12,  5, 20, 0, 1,   9,  3, 24, 1};
        vecs[2] = '{    5,   4,  5,  0, 0, 0,   0,  0,  0, 2};
        vecs[3] = '{    0,   7,  5,  5, 1, 1,   8,  1,  8, 0};
        vecs[4] = '{  510, 511,  6,  6, 0, 0,   2,  1,  8, 0};
        vecs[5] = '{  100, 100,  6,  7, 1, 0,   3,  3, 24, 1};
        vecs[6] = '{    0,   0,  0,  0, 0, 1,   1,  1,  8, 0};

        // Outputs during reset.
        #1;
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_pt_valid", pt_valid, 0);
        check("rst_acc_clear", acc_clear, 0);
        check("rst_upd_start", upd_start, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_interrupt", interrupt, 0);
        check("rst_done_code", done_code, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_irq", n_int, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Bad range: interrupt one clock edge after GO is sampled, pulse is one cycle wide.
        @(posedge clk);
        #1;
        first_addr = 9'd5;
        last_addr  = 9'd4;
        go         = 1'b1;
        @(negedge clk);
        check("bad_irq_before_edge", interrupt, 0);
        @(negedge clk);
        check("bad_irq_pulse", interrupt, 1);
        check("bad_code", done_code, 2);
        check("bad_no_read", ram_rd_en, 0);
        go = 1'b0;
        @(negedge clk);
        check("bad_irq_low_after", interrupt, 0);
        check("bad_code_held", done_code, 2);

        // Abort by dropping GO when update 3 is requested.
        b_wr  = n_wr;
        b_int = n_int;
        found = 1'b0;
        @(posedge clk);
        #1;
        first_addr = 9'd0;
        last_addr  = 9'd1;
        threshold  = '0;
        delta_hi   = 50;
        dp_mode    = 0;
        resp_lat   = 1;
        cent_tag   = 88'h0A_BCDE_F012_3456_789A_BCDE;
        go         = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (upd_start && upd_idx == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        go = 1'b0;
        check("abort_reached_k3", found, 1);
        check("abort_writes_before", n_wr - b_wr, 3);
        @(negedge clk);
        check("abort_upd_start_low", upd_start, 0);
        check("abort_reg_write_low", reg_write, 0);
        repeat (10) @(negedge clk);
        check("abort_no_more_writes", n_wr - b_wr, 3);
        check("abort_no_irq", n_int - b_int, 0);
        check("abort_code", done_code, 0);

        // Reset asserted mid-stream: outputs drop immediately.
        b_int = n_int;
        found = 1'b0;
        @(posedge clk);
        #1;
        first_addr = 9'd0;
        last_addr  = 9'd200;
        threshold  = 16'd5;
        delta_hi   = 0;
        go         = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ram_rd_en) begin
                found = 1'b1;
                break;
            end
        end
        check("rstmid_streaming", found, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstmid_rd_en", ram_rd_en, 0);
        check("rstmid_addr", ram_addr, 0);
        check("rstmid_pt_valid", pt_valid, 0);
        check("rstmid_done_code", done_code, 0);
        check("rstmid_interrupt", interrupt, 0);
        go = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstmid_no_irq", n_int - b_int, 0);

        // Normal run after the reset.
        run_vec(vecs[0], 7);

`ifdef KMEANS_CTRL_TIMEOUT_EN
        // Withheld upd_done: interrupt follows the 16th stall cycle with code 11.
        found   = 1'b0;
        cnt     = 0;
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        first_addr = 9'd0;
        last_addr  = 9'd0;
        dp_mode    = 0;
        go         = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (upd_start) begin
                found = 1'b1;
                break;
            end
        end
        check("wd_upd_started", found, 1);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            cnt++;
            if (interrupt) begin
                found = 1'b1;
                break;
            end
        end
        check("wd_irq_seen", found, 1);
        check("wd_stall_cycles", cnt, 16);
        check("wd_code", done_code, 3);
        go = 1'b0;
        resp_en = 1'b1;
        repeat (3) @(negedge clk);
`else
        b_wr = 0;
        cnt  = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
